// File: rtl/rr_grant_encoder.sv
// Registered round-robin arbiter: picks one of n valid requesters per cycle,
// rotating priority, and presents the winner as a binary index plus one-hot copy.
module rr_grant_encoder #(
    parameter int unsigned m = 3,
    parameter int unsigned n = 1 << m
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [n-1:0] req_val,
    output logic [n-1:0] req_rdy,
    output logic         grant_val,
    input  logic         grant_rdy,
    output logic [m-1:0] grant_idx,
    output logic [n-1:0] grant_oh
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t       state_q;
    state_t       state_d;
    logic [m-1:0] ptr_q;
    logic [m-1:0] winner;
    logic         found;
    logic         any;
    logic         space;
    logic         accept;

    // Search ptr, ptr+1, ... with natural m-bit wrap, which is modulo n since n == 1<<m.
    always_comb begin
        logic [m-1:0] idx;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned k = 0; k < n; k++) begin
            idx = ptr_q + m'(k);
            if (!found && req_val[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // A draining register counts as space, so drain and refill share one edge.
    always_comb begin
        any     = |req_val;
        space   = (state_q == EMPTY) || grant_rdy;
        accept  = any && space && reset;
        req_rdy = '0;
        if (accept) begin
            req_rdy = n'(1) << winner;
        end
        state_d = state_q;
        if (accept) begin
            state_d = FULL;
        end else if ((state_q == FULL) && grant_rdy) begin
            state_d = EMPTY;
        end
        grant_val = (state_q == FULL);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= EMPTY;
            ptr_q     <= '0;
            grant_idx <= '0;
            grant_oh  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                grant_idx <= winner;
                grant_oh  <= n'(1) << winner;
                ptr_q     <= winner + m'(1);
            end
        end
    end

endmodule
